// File: rtl/traffic_controller.sv
// traffic_controller: fixed-time round-robin signal sequencer for a T-junction
// with West, East and North approaches. Each approach runs green, yellow and
// then an all-red clearance before the next approach gets green. The lamps are
// a Moore decode of the state register, so they change in the same cycle as
// the state.
//
// state    | meaning
// ---------+--------------------------------------------------
// W_GREEN  | West pair green, all others red
// W_YELLOW | West pair yellow, all others red
// W_CLEAR  | all red, clearance before East
// E_GREEN  | East pair green, all others red
// E_YELLOW | East pair yellow, all others red
// E_CLEAR  | all red, clearance before North
// N_GREEN  | North pair green, all others red
// N_YELLOW | North pair yellow, all others red
// N_CLEAR  | all red, clearance before West

module traffic_controller #(
    parameter int unsigned GREEN_TIME  = 25,
    parameter int unsigned YELLOW_TIME = 5,
    parameter int unsigned CLEAR_TIME  = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] w_to_e,
    output logic [2:0] w_to_n,
    output logic [2:0] e_to_w,
    output logic [2:0] e_to_n,
    output logic [2:0] n_to_e,
    output logic [2:0] n_to_w
);

    // One-hot lamp codes {red, yellow, green}.
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Last counter value of each dwell; the state advances on the edge after
    // the counter reaches this value, giving exactly T cycles per state.
    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TIME - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] CLEAR_LAST  = 8'(CLEAR_TIME - 1);

    typedef enum logic [3:0] {
        W_GREEN  = 4'd0,
        W_YELLOW = 4'd1,
        W_CLEAR  = 4'd2,
        E_GREEN  = 4'd3,
        E_YELLOW = 4'd4,
        E_CLEAR  = 4'd5,
        N_GREEN  = 4'd6,
        N_YELLOW = 4'd7,
        N_CLEAR  = 4'd8
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] dwell_last;
    logic [2:0] w_lamp;
    logic [2:0] e_lamp;
    logic [2:0] n_lamp;

    // State and dwell counter registers; reset lands on W_GREEN at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= W_GREEN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Select the terminal count for the kind of state we are in.
    always_comb begin
        dwell_last = CLEAR_LAST;
        case (state_q)
            W_GREEN, E_GREEN, N_GREEN:    dwell_last = GREEN_LAST;
            W_YELLOW, E_YELLOW, N_YELLOW: dwell_last = YELLOW_LAST;
            default:                      dwell_last = CLEAR_LAST;
        endcase
    end

    // Next-state: count up within a state, advance and clear at terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == dwell_last) begin
            cnt_d = 8'd0;
            case (state_q)
                W_GREEN:  state_d = W_YELLOW;
                W_YELLOW: state_d = W_CLEAR;
                W_CLEAR:  state_d = E_GREEN;
                E_GREEN:  state_d = E_YELLOW;
                E_YELLOW: state_d = E_CLEAR;
                E_CLEAR:  state_d = N_GREEN;
                N_GREEN:  state_d = N_YELLOW;
                N_YELLOW: state_d = N_CLEAR;
                N_CLEAR:  state_d = W_GREEN;
                default:  state_d = W_GREEN;
            endcase
        end
        // Unused encodings recover to the start of the rotation.
        if (state_q > N_CLEAR) begin
            state_d = W_GREEN;
            cnt_d   = 8'd0;
        end
    end

    // Moore lamp decode: only the active approach may leave red.
    always_comb begin
        w_lamp = LAMP_RED;
        e_lamp = LAMP_RED;
        n_lamp = LAMP_RED;
        case (state_q)
            W_GREEN:  w_lamp = LAMP_GREEN;
            W_YELLOW: w_lamp = LAMP_YELLOW;
            E_GREEN:  e_lamp = LAMP_GREEN;
            E_YELLOW: e_lamp = LAMP_YELLOW;
            N_GREEN:  n_lamp = LAMP_GREEN;
            N_YELLOW: n_lamp = LAMP_YELLOW;
            default: begin
                w_lamp = LAMP_RED;
                e_lamp = LAMP_RED;
                n_lamp = LAMP_RED;
            end
        endcase
    end

    // Both movements of an approach share one lamp.
    assign w_to_e = w_lamp;
    assign w_to_n = w_lamp;
    assign e_to_w = e_lamp;
    assign e_to_n = e_lamp;
    assign n_to_e = n_lamp;
    assign n_to_w = n_lamp;

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: a default-timed instance and a short-timed
// instance (3/1/1) share clock and reset and are compared every cycle against
// an independent timing model, with a boundary-vector table for the default.
`timescale 1ns/1ps

module tb_traffic_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk;
    logic       rst;
    logic [2:0] w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w;
    logic [2:0] s_w_to_e, s_w_to_n, s_e_to_w, s_e_to_n, s_n_to_e, s_n_to_w;

    int total;
    int bad;
    int k;

    typedef struct {
        int         cyc;
        logic [2:0] w;
        logic [2:0] e;
        logic [2:0] n;
    } vec_t;

    vec_t tbl[$];

    traffic_controller dut (
        .clk(clk), .rst(rst),
        .w_to_e(w_to_e), .w_to_n(w_to_n),
        .e_to_w(e_to_w), .e_to_n(e_to_n),
        .n_to_e(n_to_e), .n_to_w(n_to_w)
    );

    traffic_controller #(.GREEN_TIME(3), .YELLOW_TIME(1), .CLEAR_TIME(1)) dut_s (
        .clk(clk), .rst(rst),
        .w_to_e(s_w_to_e), .w_to_n(s_w_to_n),
        .e_to_w(s_e_to_w), .e_to_n(s_e_to_n),
        .n_to_e(s_n_to_e), .n_to_w(s_n_to_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {w, e, n} lamps after k edges since reset release.
    function automatic logic [8:0] model(input int kk, input int g, input int yy, input int c);
        int phase_len, p, a, r;
        logic [2:0] lamp;
        logic [8:0] res;
        phase_len = g + yy + c;
        p = kk % (3 * phase_len);
        a = p / phase_len;
        r = p % phase_len;
        if (r < g)           lamp = G;
        else if (r < g + yy) lamp = Y;
        else                 lamp = R;
        res = {R, R, R};
        if (a == 0) res[8:6] = lamp;
        else if (a == 1) res[5:3] = lamp;
        else res[2:0] = lamp;
        return res;
    endfunction

    function automatic bit legal(input logic [2:0] l);
        return (l == R) || (l == Y) || (l == G);
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%b want=%b", name, k, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s k=%0d got=0 want=1", name, k);
        end
    endtask

    // Full comparison of both instances against the model and the safety rules.
    task automatic check_all();
        int nonred;
        check("dflt_lamps", {w_to_e, e_to_w, n_to_e}, model(k, 25, 5, 2));
        check_bit("dflt_pairs", (w_to_e === w_to_n) && (e_to_w === e_to_n) && (n_to_e === n_to_w));
        check_bit("dflt_legal", legal(w_to_e) && legal(w_to_n) && legal(e_to_w) &&
                                legal(e_to_n) && legal(n_to_e) && legal(n_to_w));
        nonred = int'(w_to_e != R) + int'(e_to_w != R) + int'(n_to_e != R);
        check_bit("dflt_one_active", nonred <= 1);
        check("short_lamps", {s_w_to_e, s_e_to_w, s_n_to_e}, model(k, 3, 1, 1));
        check_bit("short_pairs", (s_w_to_e === s_w_to_n) && (s_e_to_w === s_e_to_n) &&
                                 (s_n_to_e === s_n_to_w));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
        check_all();
    endtask

    task automatic check_reset_pattern(input string name);
        check(name, {w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w}, {G, G, R, R, R, R});
        check({name, "_short"}, {s_w_to_e, s_w_to_n, s_e_to_w, s_e_to_n, s_n_to_e, s_n_to_w},
              {G, G, R, R, R, R});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        k     = 0;

        tbl.push_back('{0,  G, R, R});
        tbl.push_back('{24, G, R, R});
        tbl.push_back('{25, Y, R, R});
        tbl.push_back('{29, Y, R, R});
        tbl.push_back('{30, R, R, R});
        tbl.push_back('{31, R, R, R});
        tbl.push_back('{32, R, G, R});
        tbl.push_back('{56, R, G, R});
        tbl.push_back('{57, R, Y, R});
        tbl.push_back('{61, R, Y, R});
        tbl.push_back('{62, R, R, R});
        tbl.push_back('{63, R, R, R});
        tbl.push_back('{64, R, R, G});
        tbl.push_back('{88, R, R, G});
        tbl.push_back('{89, R, R, Y});
        tbl.push_back('{93, R, R, Y});
        tbl.push_back('{94, R, R, R});
        tbl.push_back('{96, G, R, R});

        // Reset held across three edges.
        rst = 1'b1;
        #1;
        check_reset_pattern("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_pattern("reset_hold");
        end

        // Release; sample index k counts edges since release.
        rst = 1'b0;
        k = 0;
        check_all();

        // First rotation: boundary table on top of the per-cycle model.
        for (int i = 0; i < tbl.size(); i++) begin
            while (k < tbl[i].cyc) step();
            check($sformatf("tbl_%0d", tbl[i].cyc), {w_to_e, e_to_w, n_to_e},
                  {tbl[i].w, tbl[i].e, tbl[i].n});
        end

        // Short-timed instance landmarks: E green at 5, N green at 10, wrap at 15.
        // (Checked by the per-cycle model; these are re-checked at a later rotation.)
        while (k < 1000) begin
            step();
            if (k == 905) check("short_e_start", {s_w_to_e, s_e_to_w, s_n_to_e}, {R, G, R});
            if (k == 910) check("short_n_start", {s_w_to_e, s_e_to_w, s_n_to_e}, {R, R, G});
            if (k == 915) check("short_wrap",    {s_w_to_e, s_e_to_w, s_n_to_e}, {G, R, R});
        end

        // One-cycle reset at cycle 1000, from the middle of E green.
        check("pre_reset_1000", {w_to_e, e_to_w, n_to_e}, {R, G, R});
        rst = 1'b1;
        #1;
        check_reset_pattern("reset_1000");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        check_all();

        // Run into N_YELLOW, then reset asynchronously off the clock edge.
        while (k < 90) step();
        check("n_yellow_90", {w_to_e, e_to_w, n_to_e}, {R, R, Y});
        #2;
        rst = 1'b1;
        #1;
        check_reset_pattern("reset_mid_n_yellow");
        @(posedge clk);
        @(negedge clk);
        check_reset_pattern("reset_mid_hold");
        rst = 1'b0;
        k = 0;
        check_all();

        // W green must last a full 25 cycles after release.
        while (k < 26) begin
            step();
            if (k == 24) check("w_green_full", {w_to_e, e_to_w, n_to_e}, {G, R, R});
            if (k == 25) check("w_yellow_after", {w_to_e, e_to_w, n_to_e}, {Y, R, R});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
